// File: rtl/alu_arb.sv
// Two-requester round-robin arbiter and sequencer in front of a shared N-bit ALU.
// Latency: accept at edge T, response valid after edge T+1 (fast ops) or T+SLOW_LAT (mul/div).
// Backpressure: one op in flight; both req_ready low outside IDLE; the response holds until rsp_ready.
module alu_arb #(
    parameter int N        = 32,
    parameter int SLOW_LAT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    // requester 0
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [3:0]   req0_sel,
    // requester 1
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [3:0]   req1_sel,
    // tagged response channel
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_res
);

    // ALU op codes
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_GE  = 4'd7;
    localparam logic [3:0] OP_LT  = 4'd8;
    localparam logic [3:0] OP_EQ  = 4'd9;
    localparam logic [3:0] OP_NE  = 4'd10;

    // Execute-cycle count for mul/div; the counter is 4 bits so 1..15 fits.
    localparam logic [3:0] SLOW_CNT = 4'(SLOW_LAT);
    localparam logic [3:0] FAST_CNT = 4'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;

    // Tie-break pointer: 0 favours requester 0, 1 favours requester 1.
    logic         prio;

    // Operands and tag captured at acceptance; the ALU only ever sees these.
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [3:0]   op_sel;
    logic         op_id;
    logic [3:0]   cnt;

    logic         grant0;
    logic         grant1;
    logic         accept;
    logic         gnt_id;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [3:0]   in_sel;
    logic [3:0]   cnt_load;
    logic         exec_done;
    logic         rsp_fire;
    logic [N-1:0] alu_res;

    // Round-robin grant: only in IDLE, a lone request wins, a tie goes to the favoured side.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && (!req1_valid || !prio)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;
    assign gnt_id     = grant1;

    // Payload of the granted requester and the execute length it needs.
    always_comb begin
        in_a     = gnt_id ? req1_a   : req0_a;
        in_b     = gnt_id ? req1_b   : req0_b;
        in_sel   = gnt_id ? req1_sel : req0_sel;
        cnt_load = ((in_sel == OP_MUL) || (in_sel == OP_DIV)) ? SLOW_CNT : FAST_CNT;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and FSM outputs; a request seen in RESP waits for the following IDLE cycle.
    always_comb begin
        state_nxt = state;
        rsp_valid = 1'b0;
        exec_done = 1'b0;
        rsp_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd1) begin
                    exec_done = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_fire  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pointer moves only on acceptance, to favour the requester that was not just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (accept) begin
            prio <= ~gnt_id;
        end
    end

    // Capture operands, op code and tag once, at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            op_sel <= '0;
            op_id  <= 1'b0;
        end else if (accept) begin
            op_a   <= in_a;
            op_b   <= in_b;
            op_sel <= in_sel;
            op_id  <= gnt_id;
        end
    end

    // Execute counter: loaded on acceptance, counts down while in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt_load;
        end else if (state == EXEC) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Shared ALU; divide by zero is forced to all ones so no X ever escapes.
    always_comb begin
        alu_res = '0;
        case (op_sel)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_MUL:  alu_res = op_a * op_b;
            OP_DIV:  alu_res = (op_b == '0) ? '1 : (op_a / op_b);
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_GE:   alu_res = {{(N-1){1'b0}}, (op_a >= op_b)};
            OP_LT:   alu_res = {{(N-1){1'b0}}, (op_a <  op_b)};
            OP_EQ:   alu_res = {{(N-1){1'b0}}, (op_a == op_b)};
            OP_NE:   alu_res = {{(N-1){1'b0}}, (op_a != op_b)};
            default: alu_res = '0;
        endcase
    end

    // Result register: loaded on the last execute cycle, held through RESP until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_res <= '0;
        end else if (exec_done) begin
            rsp_res <= alu_res;
        end else if (rsp_fire) begin
            rsp_res <= rsp_res;
        end
    end

    assign rsp_id = op_id;

endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: directed vector table, hand-written multi-cycle sequences,
// and randomized two-requester contention checked against a behavioural model.
module tb_alu_arb;

    localparam int N        = 32;
    localparam int SLOW_LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [N-1:0] req0_a = '0;
    logic [N-1:0] req0_b = '0;
    logic [3:0]   req0_sel = '0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [N-1:0] req1_a = '0;
    logic [N-1:0] req1_b = '0;
    logic [3:0]   req1_sel = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic         rsp_id;
    logic [N-1:0] rsp_res;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    alu_arb #(.N(N), .SLOW_LAT(SLOW_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_res    (rsp_res)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        id;
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference ALU written from the op-code table.
    function automatic logic [31:0] ref_alu(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (s)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    begin p = 64'(a) * 64'(b); return p[31:0]; end
            4'd3:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return (a >= b) ? 32'd1 : 32'd0;
            4'd8:    return (a <  b) ? 32'd1 : 32'd0;
            4'd9:    return (a == b) ? 32'd1 : 32'd0;
            4'd10:   return (a != b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] s);
        return (s == 4'd2 || s == 4'd3) ? SLOW_LAT : 1;
    endfunction

    task automatic drive(input logic id, input logic v, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        if (!id) begin
            req0_valid = v; req0_sel = s; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_sel = s; req1_a = a; req1_b = b;
        end
    endtask

    function automatic logic rdy(input logic id);
        return id ? req1_ready : req0_ready;
    endfunction

    // Wait (bounded) from a falling edge until rsp_valid is seen.
    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rsp_seen", rsp_valid, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One request from a single requester; payload is scrambled right after acceptance.
    task automatic run_op(input logic id, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic rid, output int lat);
        int n;
        int t;
        res = '0; rid = 1'b0; lat = -1;
        drive(id, 1, s, a, b);
        n = 0;
        #1;
        while (!rdy(id) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept_seen", rdy(id), 1);
        check("ready_excl", {req0_ready, req1_ready}, id ? 2'b01 : 2'b10);
        t = cyc + 1;
        @(negedge clk);
        drive(id, 0, 4'($urandom), $urandom, $urandom);
        wait_rsp();
        lat = cyc - t;
        res = rsp_res;
        rid = rsp_id;
        @(negedge clk);
    endtask

    vec_t        vt[16];
    logic [31:0] r_res;
    logic        r_id;
    int          r_lat;
    int          gq[$];
    int          gt[$];
    int          bad;
    int          t0;
    logic        pend[2];
    op_t         pop[2];
    logic        last_g;
    logic        exp_w;

    initial begin
        vt[0]  = '{1'b0, 4'd0,  32'd5,         32'd7,         32'd12};
        vt[1]  = '{1'b0, 4'd1,  32'd10,        32'd3,         32'd7};
        vt[2]  = '{1'b1, 4'd6,  32'hF0,        32'hFF,        32'h0F};
        vt[3]  = '{1'b1, 4'd3,  32'd100,       32'd7,         32'd14};
        vt[4]  = '{1'b1, 4'd3,  32'd9,         32'd0,         32'hFFFF_FFFF};
        vt[5]  = '{1'b0, 4'd2,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE};
        vt[6]  = '{1'b0, 4'd4,  32'hF0F0,      32'hFF00,      32'hF000};
        vt[7]  = '{1'b1, 4'd5,  32'hF0F0,      32'h0F0F,      32'hFFFF};
        vt[8]  = '{1'b0, 4'd7,  32'd5,         32'd5,         32'd1};
        vt[9]  = '{1'b1, 4'd8,  32'd5,         32'd5,         32'd0};
        vt[10] = '{1'b0, 4'd9,  32'd7,         32'd7,         32'd1};
        vt[11] = '{1'b1, 4'd10, 32'd7,         32'd7,         32'd0};
        vt[12] = '{1'b0, 4'd12, 32'd123,       32'd456,       32'd0};
        vt[13] = '{1'b1, 4'd1,  32'd3,         32'd10,        32'hFFFF_FFF9};
        vt[14] = '{1'b0, 4'd0,  32'hFFFF_FFFF, 32'd1,         32'd0};
        vt[15] = '{1'b1, 4'd8,  32'd1,         32'h8000_0000, 32'd1};

        // Reset values while rst_n is held low.
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_res", rsp_res, 0);
        check("rst_ready", {req0_ready, req1_ready}, 2'b00);
        do_reset();

        // Directed vector table.
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            run_op(vt[i].id, vt[i].sel, vt[i].a, vt[i].b, r_res, r_id, r_lat);
            check($sformatf("vec%0d_res", i), r_res, vt[i].res);
            check($sformatf("vec%0d_id", i), r_id, vt[i].id);
            check($sformatf("vec%0d_lat", i), r_lat, ref_lat(vt[i].sel));
        end
        #1;
        check("idle_after_vec", rsp_valid, 0);

        // Both requesters valid continuously: grants alternate 0,1,0,1 every 3 cycles.
        do_reset();
        rsp_ready = 1'b1;
        drive(0, 1, 4'd1, 32'd10, 32'd3);
        drive(1, 1, 4'd6, 32'hF0, 32'hFF);
        bad = 0;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (req0_ready && req1_ready) bad++;
            if (req0_ready) begin gq.push_back(0); gt.push_back(cyc); end
            if (req1_ready) begin gq.push_back(1); gt.push_back(cyc); end
            if (rsp_valid) check("alt_res", rsp_res, rsp_id ? 32'h0F : 32'd7);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        check("alt_excl", bad, 0);
        check("alt_count_ge4", gq.size() >= 4, 1);
        for (int i = 0; i < gq.size() && i < 4; i++) begin
            check($sformatf("alt_grant%0d", i), gq[i], i % 2);
            if (i > 0) check($sformatf("alt_gap%0d", i), gt[i] - gt[i-1], 3);
        end

        // Backpressure on a mul result, with both requesters waiting.
        do_reset();
        rsp_ready = 1'b0;
        drive(0, 1, 4'd2, 32'hFFFF_FFFF, 32'd2);
        #1;
        check("bp_grant0", {req0_ready, req1_ready}, 2'b10);
        @(negedge clk);
        drive(0, 1, 4'd0, 32'd1, 32'd1);
        drive(1, 1, 4'd6, 32'hF0, 32'hFF);
        wait_rsp();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_valid", rsp_valid, 1);
            check("bp_res", rsp_res, 32'hFFFF_FFFE);
            check("bp_ready", {req0_ready, req1_ready}, 2'b00);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_hs_ready", {req0_ready, req1_ready}, 2'b00);
        @(negedge clk);
        #1;
        check("bp_next_grant", {req0_ready, req1_ready}, 2'b01);
        check("bp_idle", rsp_valid, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        wait_rsp();
        check("bp_r1_res", rsp_res, 32'h0F);
        check("bp_r1_id", rsp_id, 1);
        @(negedge clk);
        run_op(0, 4'd0, 32'd1, 32'd1, r_res, r_id, r_lat);
        check("bp_r0_res", r_res, 32'd2);
        check("bp_r0_id", r_id, 0);

        // Reset during EXEC of a div: op dropped, pointer back to requester 0.
        do_reset();
        rsp_ready = 1'b1;
        drive(0, 1, 4'd3, 32'd100, 32'd7);
        #1;
        check("rx_grant", req0_ready, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rx_valid", rsp_valid, 0);
        check("rx_res", rsp_res, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (rsp_valid) bad++;
            @(negedge clk);
        end
        check("rx_no_rsp", bad, 0);
        drive(0, 1, 4'd0, 32'd1, 32'd2);
        drive(1, 1, 4'd0, 32'd3, 32'd4);
        #1;
        check("rx_ptr", {req0_ready, req1_ready}, 2'b10);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        // Reset while a response is held in RESP.
        do_reset();
        rsp_ready = 1'b0;
        drive(1, 1, 4'd0, 32'd20, 32'd22);
        #1;
        check("rr_grant1", req1_ready, 1);
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        wait_rsp();
        check("rr_held_res", rsp_res, 32'd42);
        rst_n = 1'b0;
        #1;
        check("rr_valid", rsp_valid, 0);
        check("rr_id", rsp_id, 0);
        check("rr_res", rsp_res, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;

        // Randomized contention against the model.
        do_reset();
        rsp_ready = 1'b1;
        last_g = 1'b1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int r = 0; r < 60; r++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 3) != 0) begin
                    pend[i] = 1'b1;
                    pop[i].sel = 4'($urandom_range(0, 15));
                    pop[i].a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 50));
                    case ($urandom_range(0, 3))
                        0:       pop[i].b = 32'd0;
                        1:       pop[i].b = 32'($urandom_range(1, 20));
                        2:       pop[i].b = pop[i].a;
                        default: pop[i].b = $urandom;
                    endcase
                end
            end
            if (!pend[0] && !pend[1]) begin
                @(negedge clk);
                continue;
            end
            drive(0, pend[0], pop[0].sel, pop[0].a, pop[0].b);
            drive(1, pend[1], pop[1].sel, pop[1].a, pop[1].b);
            #1;
            exp_w = (pend[0] && pend[1]) ? ~last_g : pend[1];
            check("rand_grant", {req0_ready, req1_ready}, exp_w ? 2'b01 : 2'b10);
            last_g = exp_w;
            pend[exp_w] = 1'b0;
            t0 = cyc + 1;
            @(negedge clk);
            drive(exp_w, 0, 4'($urandom), $urandom, $urandom);
            wait_rsp();
            check("rand_lat", cyc - t0, ref_lat(pop[exp_w].sel));
            check("rand_res", rsp_res, ref_alu(pop[exp_w].sel, pop[exp_w].a, pop[exp_w].b));
            check("rand_id", rsp_id, exp_w);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
